// File: rtl/prco_lsu_pkg.sv
// prco_lsu shared definitions: opcodes, LSU state encoding, timeout default.
package prco_lsu_pkg;

  localparam logic [4:0] PRCO_OP_ADD = 5'h00;
  localparam logic [4:0] PRCO_OP_LW  = 5'h10;
  localparam logic [4:0] PRCO_OP_SW  = 5'h11;

  localparam int PRCO_LSU_TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_FIN  = 2'd2
  } lsu_state_e;

  function automatic logic is_mem_op(logic [4:0] op);
    return (op == PRCO_OP_LW) || (op == PRCO_OP_SW);
  endfunction

endpackage

// File: rtl/prco_lsu_timer.sv
// prco_lsu request watchdog: clearable saturating counter.
// expire flags that this increment reaches LIMIT.
module prco_lsu_timer
  import prco_lsu_pkg::*;
#(
  parameter int LIMIT = PRCO_LSU_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (inc && cnt != CW'(LIMIT))
      cnt <= cnt + CW'(1);
  end

  assign expire = inc && (cnt >= CW'(LIMIT - 1));

endmodule

// File: rtl/prco_lsu.sv
// prco_lsu: load/store stage, req/ack data-RAM port, LW writeback.
// Define PRCO_LSU_TIMEOUT_EN to abort requests after TIMEOUT_CYCLES.
module prco_lsu
  import prco_lsu_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int REG_SEL_W      = 3,
  parameter int TIMEOUT_CYCLES = PRCO_LSU_TIMEOUT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic [4:0]           i_op,
  input  logic [DATA_W-1:0]    i_addr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [REG_SEL_W-1:0] i_dst,
  output logic                 q_mem_req,
  output logic                 q_mem_we,
  output logic [DATA_W-1:0]    q_mem_addr,
  output logic [DATA_W-1:0]    q_mem_wdata,
  input  logic                 i_mem_ack,
  input  logic [DATA_W-1:0]    i_mem_rdata,
  output logic                 q_reg_we,
  output logic [REG_SEL_W-1:0] q_reg_sel,
  output logic [DATA_W-1:0]    q_reg_data,
  output logic                 q_busy,
  output logic                 q_done,
  output logic                 q_fault
);

  lsu_state_e state;
  logic [REG_SEL_W-1:0] dst;
  logic is_load;
  logic tmo;

`ifdef PRCO_LSU_TIMEOUT_EN
  prco_lsu_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (i_clk),
    .reset  (i_reset),
    .clr    (state == LSU_IDLE),
    .inc    (state == LSU_REQ && !i_mem_ack),
    .expire (tmo)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0);
  assign tmo = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= LSU_IDLE;
      dst         <= '0;
      is_load     <= 1'b0;
      q_mem_req   <= 1'b0;
      q_mem_we    <= 1'b0;
      q_mem_addr  <= '0;
      q_mem_wdata <= '0;
      q_reg_we    <= 1'b0;
      q_reg_sel   <= '0;
      q_reg_data  <= '0;
      q_busy      <= 1'b0;
      q_done      <= 1'b0;
      q_fault     <= 1'b0;
    end else begin
      q_done   <= 1'b0;
      q_fault  <= 1'b0;
      q_reg_we <= 1'b0;
      unique case (state)
        LSU_IDLE: begin
          if (i_ce && is_mem_op(i_op)) begin
            state       <= LSU_REQ;
            dst         <= i_dst;
            is_load     <= (i_op == PRCO_OP_LW);
            q_mem_req   <= 1'b1;
            q_mem_we    <= (i_op == PRCO_OP_SW);
            q_mem_addr  <= i_addr;
            q_mem_wdata <= i_wdata;
            q_busy      <= 1'b1;
          end else if (i_ce) begin
            state   <= LSU_FIN;
            q_done  <= 1'b1;
            q_fault <= 1'b1;
            q_busy  <= 1'b1;
          end
        end
        LSU_REQ: begin
          // ack wins over a timeout landing in the same cycle
          if (i_mem_ack) begin
            state     <= LSU_FIN;
            q_mem_req <= 1'b0;
            q_done    <= 1'b1;
            if (is_load) begin
              q_reg_we   <= 1'b1;
              q_reg_sel  <= dst;
              q_reg_data <= i_mem_rdata;
            end
          end else if (tmo) begin
            state     <= LSU_FIN;
            q_mem_req <= 1'b0;
            q_done    <= 1'b1;
            q_fault   <= 1'b1;
          end
        end
        LSU_FIN: begin
          state  <= LSU_IDLE;
          q_busy <= 1'b0;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prco_lsu.sv
// prco_lsu bench: directed cases plus random transactions
// against a transaction-level expectation model.
module tb_prco_lsu;
  import prco_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [4:0]  op;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [2:0]  dst;
  logic        ack;
  logic [15:0] rdata;

  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        reg_we;
  logic [2:0]  reg_sel;
  logic [15:0] reg_data;
  logic        busy;
  logic        done;
  logic        fault;

  int n_checks = 0;
  int n_pass   = 0;

  prco_lsu #(
    .DATA_W         (16),
    .REG_SEL_W      (3),
`ifdef PRCO_LSU_TIMEOUT_EN
    .TIMEOUT_CYCLES (4)
`else
    .TIMEOUT_CYCLES (64)
`endif
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_ce        (ce),
    .i_op        (op),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_dst       (dst),
    .q_mem_req   (mem_req),
    .q_mem_we    (mem_we),
    .q_mem_addr  (mem_addr),
    .q_mem_wdata (mem_wdata),
    .i_mem_ack   (ack),
    .i_mem_rdata (rdata),
    .q_reg_we    (reg_we),
    .q_reg_sel   (reg_sel),
    .q_reg_data  (reg_data),
    .q_busy      (busy),
    .q_done      (done),
    .q_fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One access: waits = cycles of REQ before the ack cycle.
  // noise drives stray i_ce / address changes while busy.
  task automatic txn(input logic [4:0] top, input logic [15:0] a,
                     input logic [15:0] wd, input logic [15:0] rd,
                     input logic [2:0] d, input int waits,
                     input bit noise);
    bit legal;
    bit ld;
    legal = (top == PRCO_OP_LW) || (top == PRCO_OP_SW);
    ld    = (top == PRCO_OP_LW);
    @(negedge clk);
    ce = 1'b1; op = top; addr = a; wdata = wd; dst = d;
    @(posedge clk);
    if (legal) begin
      for (int i = 0; i <= waits; i++) begin
        @(negedge clk);
        check("req", mem_req, 1);
        check("we", mem_we, !ld);
        check("addr", mem_addr, a);
        check("wdata", mem_wdata, wd);
        check("busy_req", busy, 1);
        check("done_early", done, 0);
        ce    = noise ? 1'($urandom % 2) : 1'b0;
        op    = PRCO_OP_LW;
        addr  = 16'($urandom);
        wdata = 16'($urandom);
        dst   = 3'($urandom);
        ack   = (i == waits);
        rdata = (i == waits) ? rd : 16'($urandom);
        @(posedge clk);
      end
    end
    @(negedge clk);
    ce = 1'b0; ack = 1'b0;
    check("done", done, 1);
    check("fault", fault, !legal);
    check("reg_we", reg_we, legal && ld);
    check("req_fin", mem_req, 0);
    check("busy_fin", busy, 1);
    if (legal && ld) begin
      check("reg_sel", reg_sel, d);
      check("reg_data", reg_data, rd);
    end
    @(negedge clk);
    check("busy_idle", busy, 0);
    check("done_idle", done, 0);
    check("reg_we_idle", reg_we, 0);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; op = '0; addr = '0; wdata = '0;
    dst = '0; ack = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_regwe", reg_we, 0);
    check("rst_fault", fault, 0);
    check("rst_addr", mem_addr, 0);
    reset = 1'b0;

    txn(PRCO_OP_LW, 16'h0010, 16'h0000, 16'hBEEF, 3'd3, 0, 0);
    txn(PRCO_OP_SW, 16'hFFFF, 16'h1234, 16'h0000, 3'd0, 3, 0);
    txn(PRCO_OP_ADD, 16'h0040, 16'h5555, 16'h0000, 3'd1, 0, 0);
    txn(PRCO_OP_LW, 16'h0010, 16'h0000, 16'hCAFE, 3'd5, 3, 1);

    // stray ack while idle must not start anything
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    check("idle_ack_busy", busy, 0);
    check("idle_ack_done", done, 0);
    ack = 1'b0;

    // reset in the middle of a request
    @(negedge clk);
    ce = 1'b1; op = PRCO_OP_LW; addr = 16'h0080; dst = 3'd2;
    @(negedge clk);
    ce = 1'b0;
    check("rst_mid_req", mem_req, 1);
    reset = 1'b1; ack = 1'b1; rdata = 16'hDEAD;
    @(negedge clk);
    check("rst_mid_req_drop", mem_req, 0);
    check("rst_mid_busy", busy, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_done", done, 0);
      check("rst_mid_regwe", reg_we, 0);
    end
    ack = 1'b0;

`ifdef PRCO_LSU_TIMEOUT_EN
    @(negedge clk);
    ce = 1'b1; op = PRCO_OP_SW; addr = 16'h0100; wdata = 16'hAAAA;
    @(negedge clk);
    ce = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("tmo_req", mem_req, 1);
      @(negedge clk);
    end
    check("tmo_req_drop", mem_req, 0);
    check("tmo_done", done, 1);
    check("tmo_fault", fault, 1);
    check("tmo_regwe", reg_we, 0);
    @(negedge clk);
    check("tmo_idle", busy, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      int r;
      logic [4:0] rop;
      r = int'($urandom % 8);
      if (r < 3)      rop = PRCO_OP_LW;
      else if (r < 6) rop = PRCO_OP_SW;
      else            rop = (r == 6) ? PRCO_OP_ADD : 5'h1F;
      txn(rop, 16'($urandom), 16'($urandom), 16'($urandom),
          3'($urandom), int'($urandom % 4), 1'($urandom % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
